lcd_ctrl: RTL and testbench

- Consumer end of the memory-mapped LCD register: takes the 32-bit command word the load/store path writes to the LCD address and drives the HD44780-style character LCD pins with correct write-cycle timing.
- Runs the power-up initialisation sequence on its own after reset.
- Exposes a ready/valid handshake toward the LSU and a 32-bit status word that software can read back to poll busy.

---
 rtl/lcd_ctrl.sv | 121 ++++++++++++
 tb/tb_lcd_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns 32-bit LCD command words into HD44780 write cycles and
// runs the controller's power-up initialisation sequence after reset.
module lcd_ctrl #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 4,
    parameter int T_EN      = 25,
    parameter int T_HOLD    = 4,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int CNT_W     = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_word,
    input  logic        i_lcd_valid,
    output logic        o_lcd_ready,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic [31:0] o_lcd_status
);
    typedef enum logic [2:0] {PWRUP, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       data, data_d, rom;
    logic             init_done, init_done_d, rs, rs_d, on, on_d;
    logic             run, clear, cnt_zero, unused_bits;

    assign rom         = (idx < 3'd2) ? 8'h38 : (idx == 3'd2) ? 8'h0C : (idx == 3'd3) ? 8'h01 : 8'h06;
    // clear/home commands need the long execution wait
    assign clear       = ~rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    assign cnt_zero    = cnt == '0;
    assign unused_bits = ^i_lcd_word[30:9];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= PWRUP;
            cnt       <= '0;
            idx       <= '0;
            init_done <= 1'b0;
            rs        <= 1'b0;
            data      <= '0;
            on        <= 1'b0;
            run       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            init_done <= init_done_d;
            rs        <= rs_d;
            data      <= data_d;
            on        <= on_d;
            run       <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt_zero ? cnt : cnt - 1'b1;
        idx_d       = idx;
        init_done_d = init_done;
        rs_d        = rs;
        data_d      = data;
        on_d        = on;
        case (state)
            PWRUP: begin
                on_d  = 1'b1;
                cnt_d = cnt + 1'b1;
                if (cnt == CNT_W'(T_POWERUP - 1))
                    state_d = INIT_LOAD;
            end
            INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = rom;
                state_d = SETUP;
                cnt_d   = CNT_W'(T_SETUP - 1);
            end
            SETUP: if (cnt_zero) begin
                state_d = PULSE;
                cnt_d   = CNT_W'(T_EN - 1);
            end
            PULSE: if (cnt_zero) begin
                state_d = HOLD;
                cnt_d   = CNT_W'(T_HOLD - 1);
            end
            HOLD: if (cnt_zero) begin
                state_d = WAIT;
                cnt_d   = clear ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
            end
            WAIT: if (cnt_zero) begin
                state_d = IDLE;
                if (!init_done) begin
                    idx_d       = idx + 1'b1;
                    init_done_d = idx == 3'd4;
                    state_d     = (idx == 3'd4) ? IDLE : INIT_LOAD;
                end
            end
            IDLE: if (i_lcd_valid) begin
                state_d = SETUP;
                cnt_d   = CNT_W'(T_SETUP - 1);
                on_d    = i_lcd_word[31];
                rs_d    = i_lcd_word[8];
                data_d  = i_lcd_word[7:0];
            end
            default: state_d = PWRUP;
        endcase
    end

    assign o_lcd_ready  = state == IDLE;
    assign o_lcd_en     = state == PULSE;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_on     = on;
    assign o_lcd_rs     = rs;
    assign o_lcd_data   = data;
    // busy is held low while in reset so the whole status word reads 0
    assign o_lcd_status = {16'd0, data, 6'd0, init_done, run & ~o_lcd_ready};
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: random and directed stimulus for lcd_ctrl, checked every cycle
// against a transaction-level timing model of the LCD write cycle.
module tb_lcd_ctrl;
    localparam int P = 20, S = 2, E = 3, H = 2, X = 10, C = 30;

    logic        i_clk = 1'b0, i_rst = 1'b1, i_lcd_valid = 1'b0;
    logic [31:0] i_lcd_word = '0;
    logic        o_lcd_ready, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0]  o_lcd_data;
    logic [31:0] o_lcd_status;

    lcd_ctrl #(.T_POWERUP(P), .T_SETUP(S), .T_EN(E), .T_HOLD(H), .T_EXEC(X), .T_CLEAR(C), .CNT_W(20)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_lcd_word(i_lcd_word), .i_lcd_valid(i_lcd_valid),
        .o_lcd_ready(o_lcd_ready), .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs),
        .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data), .o_lcd_status(o_lcd_status)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each command accepted at edge N gives EN over edges [N+S, N+S+E)
    // and ready again from edge N+S+E+H+wait.
    logic [7:0] init_rom [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         cyc, n_init, next_acc, rdy_at, en_r, en_f;
    logic       m_rs, m_on, m_done, m_live, exp_rdy, exp_en, prev_en;
    logic [7:0] m_data;
    logic [7:0] en_q [$];

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? C : X;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cyc = 0; n_init = 0; next_acc = P + 1; rdy_at = 0; en_r = -1; en_f = -1;
            m_rs = 0; m_data = '0; m_on = 0; m_done = 0; m_live = 0;
        end else begin
            cyc++;
            m_live = 1;
            if (!m_done) begin
                m_on = 1;
                if (n_init < 5 && cyc == next_acc) begin
                    m_rs = 0; m_data = init_rom[n_init];
                    en_r = cyc + S; en_f = en_r + E;
                    next_acc = en_f + H + wait_of(m_rs, m_data) + 1;
                    n_init++;
                end
                if (n_init == 5 && cyc == next_acc - 1) begin
                    m_done = 1; rdy_at = cyc;
                end
            end else if (cyc > rdy_at && i_lcd_valid) begin
                m_rs = i_lcd_word[8]; m_data = i_lcd_word[7:0]; m_on = i_lcd_word[31];
                en_r = cyc + S; en_f = en_r + E;
                rdy_at = en_f + H + wait_of(m_rs, m_data);
            end
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            exp_rdy = m_done && cyc >= rdy_at;
            exp_en  = cyc >= en_r && cyc < en_f;
            chk("en", o_lcd_en, exp_en);
            chk("ready", o_lcd_ready, exp_rdy);
            chk("on", o_lcd_on, m_on);
            chk("rs", o_lcd_rs, m_rs);
            chk("data", o_lcd_data, m_data);
            chk("rw", o_lcd_rw, 1'b0);
            chk("status", o_lcd_status, m_live ? {16'd0, m_data, 6'd0, m_done, !exp_rdy} : 32'd0);
            if (o_lcd_en && !prev_en) en_q.push_back(o_lcd_data);
            prev_en = o_lcd_en;
        end else prev_en = 0;
    end

    task automatic wait_ready(input int lim);
        int n = 0;
        while (!o_lcd_ready && n < lim) begin
            @(negedge i_clk);
            n++;
        end
        chk("ready_wait", o_lcd_ready, 1'b1);
    endtask

    typedef struct {
        logic [31:0] word;
        logic        on;
        logic        rs;
        logic [7:0]  data;
        int          busy;
    } vec_t;

    vec_t       vt [8];
    int         lo, hi, first_en;
    logic [31:0] w;

    initial begin
        vt[0] = '{32'h8000_0141, 1'b1, 1'b1, 8'h41, S + E + H + X};
        vt[1] = '{32'h8000_0001, 1'b1, 1'b0, 8'h01, S + E + H + C};
        vt[2] = '{32'h8000_0101, 1'b1, 1'b1, 8'h01, S + E + H + X};
        vt[3] = '{32'h8000_0002, 1'b1, 1'b0, 8'h02, S + E + H + C};
        vt[4] = '{32'h8000_0003, 1'b1, 1'b0, 8'h03, S + E + H + C};
        vt[5] = '{32'h8000_0004, 1'b1, 1'b0, 8'h04, S + E + H + X};
        vt[6] = '{32'h0000_0120, 1'b0, 1'b1, 8'h20, S + E + H + X};
        vt[7] = '{32'h7FFF_FE41, 1'b0, 1'b0, 8'h41, S + E + H + X};

        repeat (3) @(negedge i_clk);
        chk("rst_en", o_lcd_en, 1'b0);
        chk("rst_ready", o_lcd_ready, 1'b0);
        chk("rst_on", o_lcd_on, 1'b0);
        chk("rst_status", o_lcd_status, 32'd0);
        i_rst = 0;
        i_lcd_valid = 1;
        i_lcd_word = 32'h8000_0141;
        @(negedge i_clk);
        chk("on_after_release", o_lcd_on, 1'b1);
        repeat (100) @(negedge i_clk) i_lcd_word = $urandom;
        i_lcd_valid = 0;
        wait_ready(1000);
        @(negedge i_clk);
        chk("init_pulses", en_q.size(), 5);
        foreach (init_rom[i]) chk("init_data", (en_q.size() > i) ? en_q[i] : 8'hxx, init_rom[i]);
        chk("init_status", o_lcd_status, 32'h0000_0602);

        foreach (vt[i]) begin
            wait_ready(200);
            i_lcd_word = vt[i].word;
            i_lcd_valid = 1;
            @(negedge i_clk);
            i_lcd_valid = 0;
            lo = 0; hi = 0; first_en = -1;
            while (!o_lcd_ready && lo < 200) begin
                if (o_lcd_en) begin
                    hi++;
                    if (first_en < 0) first_en = lo;
                    chk("vec_rs", o_lcd_rs, vt[i].rs);
                    chk("vec_data", o_lcd_data, vt[i].data);
                end
                chk("vec_busy_bit", o_lcd_status[0], 1'b1);
                lo++;
                @(negedge i_clk);
            end
            chk("vec_busy_len", lo, vt[i].busy);
            chk("vec_en_len", hi, E);
            chk("vec_en_start", first_en, S);
            chk("vec_on", o_lcd_on, vt[i].on);
        end

        wait_ready(200);
        en_q.delete();
        i_lcd_word = 32'h8000_0141;
        i_lcd_valid = 1;
        @(negedge i_clk);
        i_lcd_word = 32'h8000_0142;
        wait_ready(200);
        @(negedge i_clk);
        i_lcd_valid = 0;
        wait_ready(200);
        @(negedge i_clk);
        chk("cont_pulses", en_q.size(), 2);
        chk("cont_first", (en_q.size() > 0) ? en_q[0] : 8'hxx, 8'h41);
        chk("cont_second", (en_q.size() > 1) ? en_q[1] : 8'hxx, 8'h42);

        repeat (400) begin
            @(negedge i_clk);
            i_lcd_valid = ($urandom_range(0, 3) == 0);
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[7:0] = 8'($urandom_range(0, 4));
            i_lcd_word = w;
        end
        i_lcd_valid = 0;

        wait_ready(200);
        i_lcd_word = 32'h8000_0155;
        i_lcd_valid = 1;
        @(negedge i_clk);
        i_lcd_valid = 0;
        lo = 0;
        while (!o_lcd_en && lo < 20) begin
            @(negedge i_clk);
            lo++;
        end
        chk("pre_rst_en", o_lcd_en, 1'b1);
        #2 i_rst = 1;
        #1;
        chk("async_rst_en", o_lcd_en, 1'b0);
        chk("async_rst_ready", o_lcd_ready, 1'b0);
        chk("async_rst_status", o_lcd_status, 32'd0);
        chk("async_rst_on", o_lcd_on, 1'b0);
        @(negedge i_clk);
        en_q.delete();
        i_rst = 0;
        wait_ready(1000);
        @(negedge i_clk);
        chk("restart_pulses", en_q.size(), 5);
        chk("restart_first", (en_q.size() > 0) ? en_q[0] : 8'hxx, 8'h38);
        chk("restart_status", o_lcd_status, 32'h0000_0602);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
